// File: rtl/multi_edge_detector_pkg.sv
// Shared mode encoding and default parameters for multi_edge_detector.
package multi_edge_detector_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int DEF_CH          = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STRETCH     = 1;

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, edge detect, retriggerable pulse stretcher, optional sticky flag
// (MULTI_EDGE_DETECTOR_STICKY_EN). Pulse registered SYNC_STAGES+1 edges after input change.
module edge_det_channel
  import multi_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STRETCH     = DEF_STRETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       pulse,
  output logic       pulse_nxt,
  output logic       sticky
);

  localparam int CW = $clog2(STRETCH + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_nxt;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   qual;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  always_comb begin
    qual = 1'b0;
    case (edge_mode_e'(mode))
      EDGE_RISE: qual = rise;
      EDGE_FALL: qual = fall;
      EDGE_BOTH: qual = rise | fall;
      default:   qual = 1'b0;
    endcase
    qual = qual & en;
  end

  // A qualified edge always reloads, so a retrigger stretches the pulse without a gap.
  always_comb begin
    cnt_nxt = '0;
    if (qual) begin
      cnt_nxt = CW'(STRETCH);
    end else if (cnt_q != '0) begin
      cnt_nxt = cnt_q - CW'(1);
    end
  end

  assign pulse_nxt = (cnt_nxt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= s;
      cnt_q  <= cnt_nxt;
      pulse  <= pulse_nxt;
    end
  end

`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (qual) begin
      sticky_q <= 1'b1;
    end else if (clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign sticky     = 1'b0;
`endif

endmodule

// File: rtl/multi_edge_detector.sv
// CH-channel async edge detector with stretched pulses and optional sticky flags
// (MULTI_EDGE_DETECTOR_STICKY_EN); pulse at SYNC_STAGES+1 edges after input change, no backpressure.
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int CH          = DEF_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STRETCH     = DEF_STRETCH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   sig_in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   pulse,
  output logic            any_pulse,
  output logic [CH-1:0]   sticky
);

  localparam int WARM_DONE = SYNC_STAGES + 1;
  localparam int WW        = $clog2(WARM_DONE + 1);

  logic [WW-1:0] warm_q;
  logic          en;
  logic [CH-1:0] pulse_nxt;

  // Holds detection off until the synchronisers and prev hold post-reset data.
  assign en = (warm_q == WW'(WARM_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q <= '0;
    end else if (!en) begin
      warm_q <= warm_q + WW'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .STRETCH    (STRETCH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sig_in   (sig_in[i]),
      .mode     (mode[2*i +: 2]),
      .clr      (clr[i]),
      .pulse    (pulse[i]),
      .pulse_nxt(pulse_nxt[i]),
      .sticky   (sticky[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_pulse <= 1'b0;
    end else begin
      any_pulse <= |pulse_nxt;
    end
  end

endmodule
